// File: rtl/binary_gray_codec.sv
`default_nettype none
// ============================================================================
//  Module      : binary_gray_codec
//  Description : Registered binary<->reflected-Gray converter with a
//                single-step monitor on the Gray-domain word stream.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          rising-edge clock
//    rst_n        asynchronous active-low reset
//    i_in_valid   i_din / i_mode sampled on this clock edge when high
//    i_mode       0 = binary->Gray, 1 = Gray->binary
//    i_din        WIDTH-bit input word
//    o_out_valid  o_dout / o_step_ok valid this cycle (registered i_in_valid)
//    o_dout       converted word, holds between valid beats
//    o_step_ok    Gray-domain word differs from the previous valid one in
//                 exactly one bit position
//  Parameters
//    WIDTH        data width, 2..32
// ============================================================================
module binary_gray_codec #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_step_ok
);

  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] w_b2g;
  logic [WIDTH-1:0] w_g2b;
  logic [WIDTH-1:0] w_conv;
  logic [WIDTH-1:0] w_gray;
  logic [WIDTH-1:0] w_diff;
  logic             w_one_bit;

  logic [WIDTH-1:0] r_prev_gray;
  logic             r_have_prev;

  // Binary -> Gray: each bit is the XOR of itself and its upper neighbour;
  // the MSB passes straight through.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b2g
      if (gi == WIDTH - 1) begin : g_msb
        assign w_b2g[gi] = i_din[gi];
      end else begin : g_lsb
        assign w_b2g[gi] = i_din[gi+1] ^ i_din[gi];
      end
    end
  endgenerate

  // Gray -> binary: running XOR from the MSB downwards. A local
  // accumulator keeps the chain out of a self-referencing vector.
  always_comb begin
    logic w_acc;
    w_acc = 1'b0;
    w_g2b = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_acc    = w_acc ^ i_din[i];
      w_g2b[i] = w_acc;
    end
  end

  // In mode 0 the Gray-domain word is the converter output; in mode 1 it is
  // the input itself, so the step monitor always compares Gray words.
  assign w_conv = i_mode ? w_g2b : w_b2g;
  assign w_gray = i_mode ? i_din : w_b2g;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_diff    = w_gray ^ r_prev_gray;
  assign w_one_bit = (w_diff != '0) && ((w_diff & (w_diff - c_ONE)) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out_valid <= 1'b0;
      o_dout      <= '0;
      o_step_ok   <= 1'b0;
      r_prev_gray <= '0;
      r_have_prev <= 1'b0;
    end else begin
      o_out_valid <= i_in_valid;
      if (i_in_valid) begin
        o_dout      <= w_conv;
        o_step_ok   <= r_have_prev & w_one_bit;
        r_prev_gray <= w_gray;
        r_have_prev <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_binary_gray_codec.sv
`default_nettype none
module tb_binary_gray_codec;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       v4, m4;
  logic [3:0] d4;
  logic       ov4, st4;
  logic [3:0] q4;

  // WIDTH=8 instance
  logic       v8, m8;
  logic [7:0] d8;
  logic       ov8, st8;
  logic [7:0] q8;

  binary_gray_codec #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(v4), .i_mode(m4), .i_din(d4),
    .o_out_valid(ov4), .o_dout(q4), .o_step_ok(st4)
  );

  binary_gray_codec #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(v8), .i_mode(m8), .i_din(d8),
    .o_out_valid(ov8), .o_dout(q8), .o_step_ok(st8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: Gray code of n is n XOR n/2; the inverse is found by
  // searching the code table for the matching entry.
  function automatic logic [7:0] gray8(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] inv8(input logic [7:0] g);
    for (int b = 0; b < 256; b++) begin
      logic [7:0] bb;
      bb = b[7:0];
      if (gray8(bb) == g) return bb;
    end
    return 8'h00;
  endfunction

  typedef struct {
    logic       mode;
    logic [3:0] din;
    logic [3:0] dout;
    logic       step;
  } vec_t;

  vec_t tbl[$];
  logic [3:0] gseq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  initial begin
    vec_t v;
    logic       have;
    logic [7:0] prev_g, last_b, last_q, b, gw, exp_q;
    logic       exp_s;

    rst_n = 1'b0;
    v4 = 1'b0; m4 = 1'b0; d4 = '0;
    v8 = 1'b0; m8 = 1'b0; d8 = '0;

    // ---------------- vector table (WIDTH=4) ----------------
    for (int i = 0; i < 16; i++) begin
      v.mode = 1'b0; v.din = 4'(i); v.dout = gseq[i]; v.step = (i != 0);
      tbl.push_back(v);
    end
    // Inverse sweep: history carries over, Gray 1000 -> 0000 is one step.
    for (int i = 0; i < 16; i++) begin
      v.mode = 1'b1; v.din = gseq[i]; v.dout = 4'(i); v.step = 1'b1;
      tbl.push_back(v);
    end
    // Wrap-around, jump, repeat. Previous Gray word is 1000.
    v = '{1'b0, 4'b1111, 4'b1000, 1'b0}; tbl.push_back(v); // repeat of 1000
    v = '{1'b0, 4'b0000, 4'b0000, 1'b1}; tbl.push_back(v); // wrap
    v = '{1'b0, 4'b0101, 4'b0111, 1'b0}; tbl.push_back(v); // jump
    v = '{1'b0, 4'b0101, 4'b0111, 1'b0}; tbl.push_back(v); // repeat
    v = '{1'b1, 4'b1000, 4'b1111, 1'b0}; tbl.push_back(v); // spot: 0111->1000
    v = '{1'b0, 4'b0101, 4'b0111, 1'b0}; tbl.push_back(v); // 1000->0111

    #12;
    check("reset_valid", {31'b0, ov4}, 32'd0);
    check("reset_dout",  {28'b0, q4},  32'd0);
    check("reset_step",  {31'b0, st4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      v4 = 1'b1; m4 = tbl[i].mode; d4 = tbl[i].din;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_valid", i), {31'b0, ov4}, 32'd1);
      check($sformatf("tbl%0d_dout", i),  {28'b0, q4},  {28'b0, tbl[i].dout});
      check($sformatf("tbl%0d_step", i),  {31'b0, st4}, {31'b0, tbl[i].step});
    end

    // ---------------- gaps ----------------
    @(negedge clk); v4 = 1'b0; d4 = 4'b1010; m4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("gap_valid", {31'b0, ov4}, 32'd0);
      check("gap_hold",  {28'b0, q4},  32'h7);
    end
    @(negedge clk); v4 = 1'b1; m4 = 1'b0; d4 = 4'b0100; // Gray 0110 vs 0111
    @(posedge clk); #1;
    check("gap_beat_dout", {28'b0, q4},  32'h6);
    check("gap_beat_step", {31'b0, st4}, 32'd1);
    check("gap_beat_vld",  {31'b0, ov4}, 32'd1);

    // ---------------- async reset mid-stream ----------------
    @(negedge clk); d4 = 4'b0101;                        // Gray 0111, one step
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, ov4}, 32'd0);
    check("arst_dout",  {28'b0, q4},  32'd0);
    check("arst_step",  {31'b0, st4}, 32'd0);
    @(negedge clk); rst_n = 1'b1; d4 = 4'b0110;          // Gray 0101
    @(posedge clk); #1;
    check("post_rst_dout", {28'b0, q4},  32'h5);
    check("post_rst_step", {31'b0, st4}, 32'd0);
    @(negedge clk); d4 = 4'b0111;                        // Gray 0100
    @(posedge clk); #1;
    check("post_rst2_dout", {28'b0, q4},  32'h4);
    check("post_rst2_step", {31'b0, st4}, 32'd1);
    @(negedge clk); v4 = 1'b0;

    // ---------------- random WIDTH=8 against model ----------------
    have = 1'b0; prev_g = '0; last_b = '0; last_q = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 1000; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 7) == 0) begin
          v8 = 1'b0; d8 = 8'($urandom); m8 = 1'($urandom);
          @(posedge clk); #1;
          check("rnd_idle_valid", {31'b0, ov8}, 32'd0);
          check("rnd_idle_hold",  {24'b0, q8},  {24'b0, last_q});
          continue;
        end
        if ($urandom_range(0, 1) == 0) b = last_b + 8'd1;
        else                           b = 8'($urandom);
        v8 = 1'b1;
        m8 = ph[0];
        if (ph == 0) begin
          d8 = b;  gw = gray8(b); exp_q = gray8(b);
        end else begin
          d8 = gray8(b); gw = d8; exp_q = b;   // round trip back to b
        end
        exp_s  = have && ($countones(gw ^ prev_g) == 1);
        have   = 1'b1;
        prev_g = gw;
        last_b = b;
        last_q = exp_q;
        @(posedge clk); #1;
        check($sformatf("rnd_m%0d_dout", ph), {24'b0, q8},  {24'b0, exp_q});
        check($sformatf("rnd_m%0d_step", ph), {31'b0, st8}, {31'b0, exp_s});
        check($sformatf("rnd_m%0d_vld", ph),  {31'b0, ov8}, 32'd1);
        if (ph == 1)
          check("rnd_inv_model", {24'b0, q8}, {24'b0, inv8(d8)});
      end
    end
    @(negedge clk); v8 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/binary_gray_codec.md
# binary_gray_codec

Registered, parameterizable binary/Gray code converter with a selectable direction and a single-step monitor. It converts a WIDTH-bit binary word to reflected Gray code, or Gray back to binary, one word per valid beat. It is intended for counter-pointer encoding, for example FIFO pointers crossing clock domains, and for code-sequence checking in the datapath. Default WIDTH=4 covers the 16-entry code set.

## Interface
- WIDTH, default 4: data width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  din/mode sampled on this clk edge when high.
- mode  input  1  0 = binary→Gray, 1 = Gray→binary.
- din  input  WIDTH  input word.
- out_valid  output  1  dout/step_ok valid this cycle.
- dout  output  WIDTH  converted word.
- step_ok  output  1  high when the current Gray-domain word differs from the previous valid Gray-domain word in exactly one bit.

## Operation
- Binary→Gray (mode=0): dout[WIDTH-1] = din[WIDTH-1]; dout[i] = din[i+1] ^ din[i] for i < WIDTH-1.
- Gray→binary (mode=1): dout[WIDTH-1] = din[WIDTH-1]; dout[i] = dout[i+1] ^ din[i], computed as a prefix-XOR from MSB down.
- Gray-domain word: in mode 0 this is the dout value; in mode 1 it is din.
- The block holds the last valid Gray-domain word in an internal register (prev_gray) and a flag (have_prev).
- step_ok = have_prev AND popcount(gray_word ^ prev_gray) == 1.
  - The first valid beat after reset gives step_ok=0.
  - A repeated word (zero bits changed) gives step_ok=0.
- prev_gray and have_prev update on every valid beat in either mode.
  - A mode change does not clear have_prev; the comparison stays in the Gray domain.
- With in_valid low, dout, prev_gray and have_prev hold their values. out_valid drops to 0.
- Arithmetic is pure bitwise and width-exact. No carries, no saturation. Wrap-around from all-ones to zero is a legal single step in the Gray domain: binary 1111→0000 is Gray 1000→0000.

## Timing
- Latency: 1 clock. A valid beat at edge N gives dout, out_valid=1 and step_ok after edge N.
- Throughput: one word per clock. Back-to-back valid beats are fully supported.
- out_valid is a registered copy of in_valid.
- No backpressure; downstream must accept every out_valid beat.
- Reset: asserting rst_n low immediately forces dout=0, out_valid=0, step_ok=0, prev_gray=0 and have_prev=0, independent of clk.
- Release of rst_n is synchronized externally. The first edge with rst_n high may capture a valid beat.
- Reset in the middle of a stream discards the in-flight beat. The next valid beat is treated as the first, so step_ok=0.
- mode is sampled only with in_valid. A mode change between consecutive beats takes effect on the next beat with no bubble.

## Test plan
- Binary sweep, mode=0, din 0..15 on consecutive cycles → dout 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, one cycle later. step_ok=0 on the first beat and 1 on every later beat.
- Inverse sweep, mode=1, din = the Gray sequence above → dout 0..15 in order. Spot check: din=1000 → dout=1111.
- Wrap-around, mode=0, din 1111 then 0000 → dout 1000 then 0000, with step_ok=1 on the second beat. A non-adjacent jump 0000→0101 (Gray 0000→0111) gives step_ok=0. A repeated word gives step_ok=0.
- Gaps: valid beats separated by idle cycles → dout holds and out_valid=0 during gaps. step_ok compares against the last valid word.
- Async reset mid-stream: drop rst_n between edges → outputs go to 0 immediately. After release, the first valid beat has step_ok=0.
- WIDTH=8, mode=0 then mode=1, random 1000 words → dout matches the XOR reference in both directions. Round trip Gray→binary of the binary→Gray result equals the original word.
